// File: rtl/cong_noi_tiep_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width expression.
package cong_noi_tiep_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_bits(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/CONG_TOAN_PHAN.sv
// One-bit full adder cell.
// Combinational, zero latency; no flow control.
// Always ready: outputs follow inputs.
module CONG_TOAN_PHAN (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic COUT
);

  assign S    = A ^ B ^ CIN;
  assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/cong_noi_tiep.sv
// Bit-serial adder: {COUT,S} = A + B + CIN, one bit per clock, LSB first.
// Latency WIDTH cycles from the accepted START edge to the one-cycle DONE pulse.
// No queuing: START is only sampled in IDLE and ignored while BUSY.
module cong_noi_tiep
  import cong_noi_tiep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             load, shift, finish;
  logic             s_i, co_i;

  CONG_TOAN_PHAN u_fa (
    .A    (sa[0]),
    .B    (sb[0]),
    .CIN  (c),
    .S    (s_i),
    .COUT (co_i)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        shift = 1'b1;
        if (cnt == LAST) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // BUSY is a decode of the state register so that reset clears it instantly
  assign BUSY = (state == ST_RUN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      COUT  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nx;
      DONE  <= finish;
      if (load) begin
        sa  <= A;
        sb  <= B;
        c   <= CIN;
        cnt <= '0;
      end else if (shift) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        res <= {s_i, res[WIDTH-1:1]};
        c   <= co_i;
        // cnt wraps to zero on the last bit, so it never exceeds WIDTH-1
        cnt <= finish ? '0 : cnt + CW'(1);
      end
      if (finish) begin
        S    <= {s_i, res[WIDTH-1:1]};
        COUT <= co_i;
      end
    end
  end

endmodule
